matvec_mac_seq: RTL and testbench
=================================

// Module: matvec_mac_seq
// PURPOSE
//  Parametrised sequential matrix-vector multiplier: computes y = A*x for an N x N matrix A and N-vector x.
//  Input is one element pair (A[r][c], x[c]) per accepted beat, row-major; one registered multiplier feeds one accumulator.
//  Adds valid/ready flow control on both sides, signed/unsigned and saturate/wrap modes, per-row done strobes and a
//  synchronous clear. Sits between the vertex/pixel fetch stage and the transform writeback stage of the GPU datapath.
// PARAMETERS
//  N        4   matrix dimension (rows = cols = vector length), >= 2
//  DATA_W   16  operand width
//  ACC_W    32  accumulator/result width, must be >= 2*DATA_W
//  SIGNED   0   1: two's-complement operands and results; 0: unsigned
//  SAT      0   1: saturate accumulation at ACC_W limits; 0: wrap modulo 2^ACC_W
// PORTS
//  clk        in   1          clock, rising edge
//  reset_n    in   1          synchronous active-low reset
//  clear      in   1          synchronous abort: flush pipeline, counters, results; same effect as reset_n=0
//  in_valid   in   1          in1/in2 hold a valid element pair
//  in_ready   out  1          block accepts a pair this cycle
//  in1        in   DATA_W     matrix element A[r][c]
//  in2        in   DATA_W     vector element x[c]
//  row_done   out  1          one-cycle pulse: row row_idx accumulation complete
//  row_idx    out  clog2(N)   row index qualifying row_done
//  out_valid  out  1          result vector complete and held stable
//  out_ready  in   1          downstream consumes result vector
//  result     out  N*ACC_W    packed y; y[r] at result[r*ACC_W +: ACC_W]
// BEHAVIOUR
//  Reset/clear: state=ACCUM, col=row=0, pipeline valid=0, all accumulators and result=0, in_ready=1, out_valid=0,
//   row_done=0, row_idx=0. clear has priority over in_valid/out_ready in the same cycle.
//  Accept = in_valid & in_ready. in_ready = (state==ACCUM). No combinational in_valid->in_ready path.
//  Stage 1 (cycle of accept +1): prod register <= in1*in2 (2*DATA_W, signed per SIGNED), tagged with col/row.
//  Stage 2 (+2): prod extended to ACC_W (sign- or zero-extend); acc[row] <= (col==0 ? prod : acc[row]+prod).
//   SAT=1: on overflow, clamp to max (0x7F..F signed / 0xF..F unsigned) or min (0x80..0 signed / 0 unsigned); sticky
//   within the row. SAT=0: wrap.
//  Counters: col increments per accept, wraps at N-1 -> 0 and increments row; row wraps at N-1 -> 0 on final element.
//  row_done pulses in stage-2 cycle of col==N-1 element; row_idx = that row. Back-to-back beats: one result per cycle.
//  FSM: ACCUM -(accept of row N-1,col N-1)-> DRAIN (in_ready=0, pipeline empties)
//       DRAIN -(stage 2 writes last element)-> OUTPUT (out_valid=1, next cycle)
//       OUTPUT -(out_ready)-> ACCUM (out_valid=0, in_ready=1 next cycle). Latency: last accept at T -> out_valid at T+3.
//  result updates only on the DRAIN->OUTPUT transition; stable while out_valid=1 and until the next transition.
//  in_valid deasserted mid-row: counters hold, partial sums kept; gaps of any length allowed.
//  out_ready while out_valid=0: ignored. in_valid while in_ready=0: not accepted, operands ignored.
//  reset_n/clear mid-row or in DRAIN/OUTPUT: partial vector discarded, no row_done/out_valid emitted for it.
// STRUCTURE
//  Shared package gpu_pkg: mv_state_t enum {ACCUM, DRAIN, OUTPUT}; saturation min/max constant functions of
//   (ACC_W, SIGNED); clog2 helper.
//  One sub-module: mac_unit (registered multiply + extend + saturating/wrapping add, parameters DATA_W, ACC_W, SIGNED, SAT).
//  Top holds counters, FSM, accumulator array (N x ACC_W) and output register.
// TESTING
//  1 Defaults, A=[[1,1,2,3],[5,6,7,3],[1,2,3,2],[4,5,3,5]], x=[2,5,3,1], back-to-back -> y=[16,64,23,47],
//    row_done at rows 0..3, out_valid 3 cycles after 16th accept.
//  2 Same vectors, in_valid random gaps, out_ready low 5 cycles -> same y, in_ready=0 and result stable during hold.
//  3 SIGNED=1: row0=[-3,4,-1,2], x=[4,-2,7,-5] -> y[0]=-37 (0xFFFFFFDB).
//  4 SAT=1,SIGNED=1: row of 0x7FFF x 0x7FFF -> y=0x7FFFFFFF; SAT=0 same stimulus -> 0xFFFC0004.
//  5 clear after 6 accepts, then full case-1 stream -> y=[16,64,23,47], no stale row_done or out_valid.
//  6 N=2,DATA_W=8,ACC_W=20: A=[[255,255],[1,0]], x=[255,2] -> y=[65535,255].

Source files
------------

// File: rtl/gpu_pkg.sv
// ============================================================================
// gpu_pkg : shared types and constant helpers for the GPU datapath blocks
// Revision: 1.0
// ============================================================================
`default_nettype none

package gpu_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DRAIN  = 2'd1,
      OUTPUT = 2'd2
   } mv_state_t;

   localparam int SAT_CONST_W = 256;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

   // Limits are returned wide; callers keep the low acc_w bits.
   function automatic logic [SAT_CONST_W-1:0] sat_max(input int acc_w, input logic signed_mode);
      logic [SAT_CONST_W-1:0] one;
      one = 1;
      return signed_mode ? ((one << (acc_w - 1)) - one) : ((one << acc_w) - one);
   endfunction

   function automatic logic [SAT_CONST_W-1:0] sat_min(input int acc_w, input logic signed_mode);
      logic [SAT_CONST_W-1:0] one;
      one = 1;
      return signed_mode ? (one << (acc_w - 1)) : '0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/matvec_mac_seq_mac.sv
// ============================================================================
// mac_unit : registered multiplier plus extend and saturating/wrapping add
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_unit
   import gpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int SIGNED = 0,
   parameter int SAT    = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [ACC_W-1:0]  acc_i,
   input  logic              first_i,
   input  logic              sticky_i,
   output logic [ACC_W-1:0]  sum_o,
   output logic              sat_o
);

   localparam int   c_pw  = 2 * DATA_W;
   localparam logic c_sgn = (SIGNED != 0);
   localparam logic c_sat = (SAT != 0);
   localparam logic [SAT_CONST_W-1:0] c_max_full = sat_max(ACC_W, c_sgn);
   localparam logic [SAT_CONST_W-1:0] c_min_full = sat_min(ACC_W, c_sgn);
   localparam logic [ACC_W-1:0] c_max = c_max_full[ACC_W-1:0];
   localparam logic [ACC_W-1:0] c_min = c_min_full[ACC_W-1:0];

   logic [c_pw-1:0]  a_ext;
   logic [c_pw-1:0]  b_ext;
   logic [c_pw-1:0]  prod_d;
   logic [c_pw-1:0]  prod_q;
   logic [ACC_W-1:0] prod_x;
   logic [ACC_W:0]   sum_wide;
   logic             ovf;
   logic             neg;

   // Low 2*DATA_W bits of the extended product are exact in both modes.
   assign a_ext  = {{DATA_W{c_sgn & a_i[DATA_W-1]}}, a_i};
   assign b_ext  = {{DATA_W{c_sgn & b_i[DATA_W-1]}}, b_i};
   assign prod_d = a_ext * b_ext;

   always_ff @(posedge clk) begin
      if (!reset_n || clear_i) begin
         prod_q <= '0;
      end else if (en_i) begin
         prod_q <= prod_d;
      end
   end

   generate
      if (ACC_W > c_pw) begin : g_ext
         assign prod_x = {{(ACC_W - c_pw){c_sgn & prod_q[c_pw-1]}}, prod_q};
      end else begin : g_noext
         assign prod_x = prod_q;
      end
   endgenerate

   assign sum_wide = {c_sgn & acc_i[ACC_W-1], acc_i} + {c_sgn & prod_x[ACC_W-1], prod_x};
   assign neg      = c_sgn & sum_wide[ACC_W];
   assign ovf      = c_sgn ? (sum_wide[ACC_W] != sum_wide[ACC_W-1]) : sum_wide[ACC_W];

   // Once a row has clamped it stays at the clamp value until the row restarts.
   always_comb begin
      sum_o = first_i ? prod_x : sum_wide[ACC_W-1:0];
      sat_o = 1'b0;
      if (c_sat && !first_i) begin
         if (sticky_i) begin
            sum_o = acc_i;
            sat_o = 1'b1;
         end else if (ovf) begin
            sum_o = neg ? c_min : c_max;
            sat_o = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/matvec_mac_seq.sv
// ============================================================================
// matvec_mac_seq : sequential y = A*x, one element pair per beat, row-major
// Revision: 1.0
// ============================================================================
`default_nettype none

module matvec_mac_seq
   import gpu_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int SIGNED = 0,
   parameter int SAT    = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in1,
   input  logic [DATA_W-1:0]     in2,
   output logic                  row_done,
   output logic [clog2(N)-1:0]   row_idx,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N*ACC_W-1:0]    result
);

   localparam int c_iw = clog2(N);
   localparam logic [c_iw-1:0] c_last = c_iw'(N - 1);
   localparam logic [c_iw-1:0] c_one  = c_iw'(1);

   mv_state_t            state_q, state_d;
   logic [c_iw-1:0]      col_q, row_q;
   logic                 v1_q;
   logic [c_iw-1:0]      col1_q, row1_q;
   logic [ACC_W-1:0]     acc_q [N];
   logic                 sat_q;
   logic                 row_done_q;
   logic [c_iw-1:0]      row_idx_q;
   logic [N*ACC_W-1:0]   result_q;
   logic [N*ACC_W-1:0]   acc_flat;
   logic                 accept;
   logic                 last_in;
   logic                 first;
   logic [ACC_W-1:0]     sum;
   logic                 sat_now;
   logic                 flush;

   assign flush     = !reset_n || clear;
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == OUTPUT);
   assign accept    = in_valid && in_ready;
   assign last_in   = (col_q == c_last) && (row_q == c_last);
   assign first     = (col1_q == '0);
   assign row_done  = row_done_q;
   assign row_idx   = row_idx_q;
   assign result    = result_q;

   mac_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED),
      .SAT    (SAT)
   ) u_mac (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (clear),
      .en_i     (accept),
      .a_i      (in1),
      .b_i      (in2),
      .acc_i    (acc_q[row1_q]),
      .first_i  (first),
      .sticky_i (sat_q),
      .sum_o    (sum),
      .sat_o    (sat_now)
   );

   generate
      for (genvar r = 0; r < N; r++) begin : g_pack
         assign acc_flat[r*ACC_W +: ACC_W] = acc_q[r];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCUM:   if (accept && last_in) state_d = DRAIN;
         DRAIN:   if (row_done_q && (row_idx_q == c_last)) state_d = OUTPUT;
         OUTPUT:  if (out_ready) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         state_q  <= ACCUM;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == DRAIN && state_d == OUTPUT) result_q <= acc_flat;
      end
   end

   // Input-side counters and stage-1 tags travel alongside the product register.
   always_ff @(posedge clk) begin
      if (flush) begin
         col_q  <= '0;
         row_q  <= '0;
         v1_q   <= 1'b0;
         col1_q <= '0;
         row1_q <= '0;
      end else begin
         v1_q <= accept;
         if (accept) begin
            col1_q <= col_q;
            row1_q <= row_q;
            if (col_q == c_last) begin
               col_q <= '0;
               row_q <= (row_q == c_last) ? '0 : row_q + c_one;
            end else begin
               col_q <= col_q + c_one;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         for (int r = 0; r < N; r++) acc_q[r] <= '0;
         sat_q      <= 1'b0;
         row_done_q <= 1'b0;
         row_idx_q  <= '0;
      end else begin
         row_done_q <= v1_q && (col1_q == c_last);
         if (v1_q) begin
            acc_q[row1_q] <= sum;
            sat_q         <= sat_now;
            if (col1_q == c_last) row_idx_q <= row1_q;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_matvec_mac_seq.sv
// ============================================================================
// tb_matvec_mac_seq : directed and random checks of matvec_mac_seq variants
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matvec_mac_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, clear;
   int   total = 0;
   int   bad   = 0;

   // unsigned default instance
   logic         a_in_valid, a_in_ready, a_row_done, a_out_valid, a_out_ready;
   logic [15:0]  a_in1, a_in2;
   logic [1:0]   a_row_idx;
   logic [127:0] a_result;
   // signed saturating (b) and signed wrapping (c), sharing stimulus
   logic         s_in_valid, s_out_ready;
   logic [15:0]  s_in1, s_in2;
   logic         b_in_ready, b_row_done, b_out_valid, c_in_ready, c_row_done, c_out_valid;
   logic [1:0]   b_row_idx, c_row_idx;
   logic [127:0] b_result, c_result;
   // small instance
   logic         d_in_valid, d_in_ready, d_row_done, d_out_valid, d_out_ready;
   logic [7:0]   d_in1, d_in2;
   logic         d_row_idx;
   logic [39:0]  d_result;

   int          ma [16];
   int          vx [4];
   logic [31:0] ya [4];
   int          dm [4];
   int          dx [2];

   matvec_mac_seq #(.N(4), .DATA_W(16), .ACC_W(32), .SIGNED(0), .SAT(0)) u_a (
      .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in1(a_in1), .in2(a_in2), .row_done(a_row_done), .row_idx(a_row_idx),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result));

   matvec_mac_seq #(.N(4), .DATA_W(16), .ACC_W(32), .SIGNED(1), .SAT(1)) u_b (
      .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(s_in_valid), .in_ready(b_in_ready),
      .in1(s_in1), .in2(s_in2), .row_done(b_row_done), .row_idx(b_row_idx),
      .out_valid(b_out_valid), .out_ready(s_out_ready), .result(b_result));

   matvec_mac_seq #(.N(4), .DATA_W(16), .ACC_W(32), .SIGNED(1), .SAT(0)) u_c (
      .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(s_in_valid), .in_ready(c_in_ready),
      .in1(s_in1), .in2(s_in2), .row_done(c_row_done), .row_idx(c_row_idx),
      .out_valid(c_out_valid), .out_ready(s_out_ready), .result(c_result));

   matvec_mac_seq #(.N(2), .DATA_W(8), .ACC_W(20), .SIGNED(0), .SAT(0)) u_d (
      .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .in1(d_in1), .in2(d_in2), .row_done(d_row_done), .row_idx(d_row_idx),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .result(d_result));

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_u32(input int r);
      logic [63:0] s;
      s = 0;
      for (int c = 0; c < 4; c++) s += 64'(ma[r*4+c][15:0]) * 64'(vx[c][15:0]);
      return s[31:0];
   endfunction

   // Signed dot product; with sat set, clamp to 32-bit limits and hold once clamped.
   function automatic logic [31:0] ref_s(input int r, input bit sat);
      longint acc, p;
      bit     stk;
      acc = 0;
      stk = 0;
      for (int c = 0; c < 4; c++) begin
         p = longint'($signed(ma[r*4+c][15:0])) * longint'($signed(vx[c][15:0]));
         if (c == 0) acc = p;
         else if (!(sat && stk)) acc = acc + p;
         if (sat && !stk) begin
            if (acc > 64'sd2147483647) begin acc = 64'sd2147483647; stk = 1; end
            else if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; stk = 1; end
         end
      end
      return acc[31:0];
   endfunction

   function automatic logic [19:0] ref_d(input int r);
      logic [63:0] s;
      s = 0;
      for (int c = 0; c < 2; c++) s += 64'(dm[r*2+c][7:0]) * 64'(dx[c][7:0]);
      return s[19:0];
   endfunction

   task automatic run_a(input int gap_pct, input int hold, input string tag);
      int idx = 0, cyc = 0, lastacc = -1, ovc = -1, extra = 0, code = 0;
      bit acc;
      int rows[$];
      logic [127:0] held;
      a_out_ready = 1'b0;
      while (ovc < 0 && cyc < 400) begin
         if (idx < 16 && $urandom_range(99) >= gap_pct) begin
            a_in_valid = 1'b1;
            a_in1 = ma[idx][15:0];
            a_in2 = vx[idx%4][15:0];
         end else begin
            a_in_valid = (idx >= 16) ? 1'(($urandom_range(1))) : 1'b0;
            a_in1 = 16'($urandom);
            a_in2 = 16'($urandom);
         end
         acc = a_in_valid && a_in_ready;
         @(posedge clk); #1;
         if (acc) begin
            if (idx < 16) begin
               idx++;
               if (idx == 16) lastacc = cyc;
            end else extra++;
         end
         cyc++;
         if (a_row_done) rows.push_back(int'(a_row_idx));
         if (a_out_valid) ovc = cyc;
      end
      a_in_valid = 1'b0;
      check({tag, "_extra_accepts"}, extra, 0);
      check({tag, "_out_latency"}, ovc - lastacc, 3);
      check({tag, "_row_done_count"}, rows.size(), 4);
      foreach (rows[i]) code = code * 4 + rows[i];
      check({tag, "_row_done_order"}, code, 27);
      for (int r = 0; r < 4; r++) check($sformatf("%s_y%0d", tag, r), a_result[r*32 +: 32], ya[r]);
      held = a_result;
      for (int h = 0; h < hold; h++) begin
         a_in_valid = 1'b1;
         a_in1 = 16'($urandom);
         a_in2 = 16'($urandom);
         @(posedge clk); #1;
         check({tag, "_hold"}, {a_out_valid, a_in_ready, a_result}, {1'b1, 1'b0, held});
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      check({tag, "_consume"}, {a_out_valid, a_in_ready}, 2'b01);
   endtask

   task automatic run_s(input string tag);
      int idx = 0, cyc = 0;
      bit seen = 0;
      s_out_ready = 1'b0;
      while (!seen && cyc < 400) begin
         s_in_valid = (idx < 16);
         s_in1 = ma[idx%16][15:0];
         s_in2 = vx[idx%4][15:0];
         if (s_in_valid && b_in_ready) idx++;
         @(posedge clk); #1;
         cyc++;
         seen = b_out_valid;
      end
      s_in_valid = 1'b0;
      check({tag, "_out_valid"}, {seen, c_out_valid}, 2'b11);
      for (int r = 0; r < 4; r++) begin
         check($sformatf("%s_sat_y%0d", tag, r), b_result[r*32 +: 32], ref_s(r, 1));
         check($sformatf("%s_wrap_y%0d", tag, r), c_result[r*32 +: 32], ref_s(r, 0));
      end
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
   endtask

   task automatic run_d(input string tag);
      int idx = 0, cyc = 0;
      bit seen = 0;
      d_out_ready = 1'b0;
      while (!seen && cyc < 200) begin
         d_in_valid = (idx < 4);
         d_in1 = dm[idx%4][7:0];
         d_in2 = dx[idx%2][7:0];
         if (d_in_valid && d_in_ready) idx++;
         @(posedge clk); #1;
         cyc++;
         seen = d_out_valid;
      end
      d_in_valid = 1'b0;
      check({tag, "_out_valid"}, seen, 1'b1);
      for (int r = 0; r < 2; r++) check($sformatf("%s_y%0d", tag, r), d_result[r*20 +: 20], ref_d(r));
      d_out_ready = 1'b1;
      @(posedge clk); #1;
      d_out_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; clear = 1'b0;
      a_in_valid = 1'b0; a_in1 = '0; a_in2 = '0; a_out_ready = 1'b0;
      s_in_valid = 1'b0; s_in1 = '0; s_in2 = '0; s_out_ready = 1'b0;
      d_in_valid = 1'b0; d_in1 = '0; d_in2 = '0; d_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_a_ctl", {a_in_ready, a_out_valid, a_row_done, a_row_idx}, 5'b10000);
      check("reset_a_result", a_result, 128'h0);
      check("reset_d_ctl", {d_in_ready, d_out_valid, d_row_done, d_row_idx, d_result}, {1'b1, 43'h0});
      reset_n = 1'b1;

      // Directed unsigned vector, back-to-back then with gaps and a held output.
      ma = '{1, 1, 2, 3, 5, 6, 7, 3, 1, 2, 3, 2, 4, 5, 3, 5};
      vx = '{2, 5, 3, 1};
      ya = '{32'd16, 32'd64, 32'd23, 32'd47};
      run_a(0, 0, "t1");
      run_a(40, 5, "t2");

      // Abort mid-vector, then a clean vector must come out untouched.
      for (int i = 0; i < 6; i++) begin
         a_in_valid = 1'b1;
         a_in1 = ma[i][15:0];
         a_in2 = vx[i%4][15:0];
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("t5_clear_ctl", {a_in_ready, a_out_valid, a_row_done, a_row_idx}, 5'b10000);
      check("t5_clear_result", a_result, 128'h0);
      run_a(0, 0, "t5");

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) ma[i] = int'($urandom_range(65535));
         for (int i = 0; i < 4; i++) vx[i] = int'($urandom_range(65535));
         for (int r = 0; r < 4; r++) ya[r] = ref_u32(r);
         run_a(30, 2, $sformatf("rnd_u%0d", k));
      end

      // Signed dot product with mixed signs.
      for (int i = 0; i < 16; i++) ma[i] = int'($urandom_range(65535));
      ma[0] = 'hFFFD; ma[1] = 4; ma[2] = 'hFFFF; ma[3] = 2;
      vx = '{4, 'hFFFE, 7, 'hFFFB};
      run_s("t3");
      check("t3_y0_literal", b_result[31:0], 32'hFFFFFFDB);

      // Positive and negative overflow rows.
      for (int i = 0; i < 16; i++) ma[i] = int'($urandom_range(65535));
      for (int i = 0; i < 4; i++) begin
         ma[i] = 'h7FFF;
         ma[4+i] = 'h8000;
         vx[i] = 'h7FFF;
      end
      run_s("t4");
      check("t4_sat_y0_literal", b_result[31:0], 32'h7FFFFFFF);
      check("t4_wrap_y0_literal", c_result[31:0], 32'hFFFC0004);
      check("t4_sat_y1_literal", b_result[63:32], 32'h80000000);

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) ma[i] = ($urandom_range(3) == 0) ? 'h8000 : int'($urandom_range(65535));
         for (int i = 0; i < 4; i++) vx[i] = ($urandom_range(3) == 0) ? 'h7FFF : int'($urandom_range(65535));
         run_s($sformatf("rnd_s%0d", k));
      end

      // Small instance at the width boundary.
      dm = '{255, 255, 1, 0};
      dx = '{255, 2};
      run_d("t6");
      check("t6_y0_literal", d_result[19:0], 20'd65535);
      check("t6_y1_literal", d_result[39:20], 20'd255);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) dm[i] = int'($urandom_range(255));
         for (int i = 0; i < 2; i++) dx[i] = int'($urandom_range(255));
         run_d($sformatf("rnd_d%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
